// File: rtl/adder_pkg.sv
// Shared types and helpers for the adder block family.
// Holds the accumulator FSM state and the saturating add.
package adder_pkg;

  typedef enum logic {
    ACCU = 1'b0,
    HOLD = 1'b1
  } accu_state_e;

  localparam int SAT_MAXW = 63;

  typedef struct packed {
    logic                sat;
    logic [SAT_MAXW-1:0] sum;
  } sat_res_t;

  // Operands are truncated to w bits; carry out of bit w-1 clamps to all-ones.
  function automatic sat_res_t sat_add(
    input logic [SAT_MAXW-1:0] a,
    input logic [SAT_MAXW-1:0] b,
    input int unsigned         w
  );
    logic [SAT_MAXW:0]   full;
    logic [SAT_MAXW-1:0] mask;
    sat_res_t            r;
    mask  = ~({SAT_MAXW{1'b1}} << w);
    full  = {1'b0, a & mask} + {1'b0, b & mask};
    r.sat = |(full & ~{1'b0, mask});
    r.sum = r.sat ? mask : full[SAT_MAXW-1:0];
    return r;
  endfunction

endpackage

// File: rtl/adder_accu.sv
// Block accumulator behind the adder: sums cnt_len samples with
// saturation, then holds the block total on an output handshake.
module adder_accu
  import adder_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 12,
  parameter int CNT_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic [CNT_WIDTH-1:0]  cnt_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH:0]   in_sum,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_acc,
  output logic                  out_ovf
);

  if (ACC_WIDTH < DATA_WIDTH + 1) begin : g_chk_w
    $error("adder_accu: ACC_WIDTH must be >= DATA_WIDTH+1");
  end
  if (ACC_WIDTH >= SAT_MAXW) begin : g_chk_max
    $error("adder_accu: ACC_WIDTH too large for sat_add");
  end

  accu_state_e          state, state_nxt;
  logic [ACC_WIDTH-1:0] acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] len_q;
  logic                 ovf;

  logic                 accept;
  logic                 last;
  logic [CNT_WIDTH-1:0] len_eff;
  logic [CNT_WIDTH-1:0] len_m1;
  sat_res_t             res;
  logic [ACC_WIDTH-1:0] acc_sum;
  logic                 ovf_sum;
  logic                 unused_hi;

  assign res       = sat_add(SAT_MAXW'(acc), SAT_MAXW'(in_sum), ACC_WIDTH);
  assign acc_sum   = res.sum[ACC_WIDTH-1:0];
  assign ovf_sum   = ovf | res.sat;
  assign unused_hi = ^res.sum[SAT_MAXW-1:ACC_WIDTH];

  // First sample of a block uses the live length; later ones the latched copy.
  assign len_eff   = (cnt == '0) ? cnt_len : len_q;
  assign len_m1    = len_eff - CNT_WIDTH'(1);
  assign out_valid = (state == HOLD);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    accept    = 1'b0;
    last      = 1'b0;
    unique case (1'b1)
      (state == ACCU): begin
        in_ready = !rst && !clear;
        accept   = in_valid && in_ready;
        last     = accept && (cnt == len_m1);
        if (last) state_nxt = HOLD;
      end
      (state == HOLD): begin
        if (out_ready) state_nxt = ACCU;
      end
      default: state_nxt = ACCU;
    endcase
    if (clear) state_nxt = ACCU;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state   <= ACCU;
      acc     <= '0;
      cnt     <= '0;
      len_q   <= '0;
      ovf     <= 1'b0;
      out_acc <= '0;
      out_ovf <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        if (cnt == '0) len_q <= cnt_len;
        if (last) begin
          out_acc <= acc_sum;
          out_ovf <= ovf_sum;
          acc     <= '0;
          cnt     <= '0;
          ovf     <= 1'b0;
        end else begin
          acc <= acc_sum;
          ovf <= ovf_sum;
          cnt <= cnt + CNT_WIDTH'(1);
        end
      end
    end
  end

endmodule
